// File: rtl/wisc_pkg.sv
// Shared WISC-S15 definitions: opcodes, bubble encoding,
// fetch FSM states and the IF/ID payload bundle.
package wisc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_SLL  = 4'h4;
  localparam logic [3:0] OP_SRL  = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_ROL  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_LHB  = 4'hA;
  localparam logic [3:0] OP_LLB  = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_ERR  = 4'hF;

  // ADD R0,R0,R0: the register file discards R0 writes
  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_SKID  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc1;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry IF/ID holding register used while decode stalls.
// Ports: clk, rst_n, ld (capture din), clr (empty, wins), dout, vld.
module fetch_skid_buf
  import wisc_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ld,
  input  logic   clr,
  input  if_id_t din,
  output if_id_t dout,
  output logic   vld
);

  if_id_t mem_q, mem_d;
  logic   vld_q, vld_d;

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (clr) begin
      mem_d = '{instr: NOP_INSTR, pc1: 16'h0000, valid: 1'b0};
      vld_d = 1'b0;
    end else if (ld) begin
      mem_d = din;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{instr: NOP_INSTR, pc1: 16'h0000, valid: 1'b0};
      vld_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
    end
  end

  assign dout = mem_q;
  assign vld  = vld_q;

endmodule

// File: rtl/fetch_if_id_stage.sv
// WISC-S15 fetch stage + IF/ID register: PC, imem req/rdy, skid, redirect.
// Ports: clk, rst_n, imem_*, stall, redirect(_pc), if_id_*, opcode.
module fetch_if_id_stage
  import wisc_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
)
(
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc1,
  output logic        if_id_valid,
  output logic [3:0]  opcode
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  tgt_q, tgt_d;
  if_id_t       ifid_q, ifid_d;

  logic   req;
  logic   skid_ld, skid_clr, skid_vld;
  if_id_t skid_dout;
  if_id_t resp, bubble;

  assign resp = '{
    instr: imem_data,
    pc1:   pc_q + 16'd1,
    valid: 1'b1
  };

  // bubbles keep pc1 so the link/offset value never jumps
  assign bubble = '{
    instr: NOP_INSTR,
    pc1:   ifid_q.pc1,
    valid: 1'b0
  };

  fetch_skid_buf u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (skid_ld),
    .clr  (skid_clr),
    .din  (resp),
    .dout (skid_dout),
    .vld  (skid_vld)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    ifid_d   = ifid_q;
    req      = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;

    unique case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        if (!stall) ifid_d = bubble;
      end
      S_FETCH: begin
        req = 1'b1;
        if (imem_rdy) begin
          pc_d = pc_q + 16'd1;
          if (stall) begin
            skid_ld = 1'b1;
            state_d = S_SKID;
          end else begin
            ifid_d = resp;
          end
        end else if (!stall) begin
          ifid_d = bubble;
        end
      end
      S_DROP: begin
        // old request must complete; its data is thrown away
        req = 1'b1;
        if (imem_rdy) begin
          pc_d    = tgt_q;
          state_d = S_FETCH;
        end
        if (!stall) ifid_d = bubble;
      end
      S_SKID: begin
        if (!stall) begin
          ifid_d   = skid_vld ? skid_dout : bubble;
          skid_clr = 1'b1;
          state_d  = S_FETCH;
        end
      end
      default: begin
        state_d = S_RESET;
      end
    endcase

    if (redirect) begin
      ifid_d   = bubble;
      skid_ld  = 1'b0;
      skid_clr = 1'b1;
      tgt_d    = redirect_pc;
      if (req && !imem_rdy) begin
        // keep the old address on the bus until accepted
        state_d = S_DROP;
        pc_d    = pc_q;
      end else begin
        state_d = S_FETCH;
        pc_d    = redirect_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      ifid_q  <= '{instr: NOP_INSTR, pc1: RESET_PC, valid: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      ifid_q  <= ifid_d;
    end
  end

  assign imem_req    = req;
  assign imem_addr   = pc_q;
  assign if_id_instr = ifid_q.instr;
  assign if_id_pc1   = ifid_q.pc1;
  assign if_id_valid = ifid_q.valid;
  assign opcode      = ifid_q.instr[15:12];

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Bench for fetch_if_id_stage: directed vector table, random
// traffic against a transaction-level model, async reset check.
module tb_fetch_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc1;
  logic        if_id_valid;
  logic [3:0]  opcode;

  fetch_if_id_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdy   (imem_rdy),
    .imem_data  (imem_data),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .if_id_instr(if_id_instr),
    .if_id_pc1  (if_id_pc1),
    .if_id_valid(if_id_valid),
    .opcode     (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc1;
  } rec_t;

  bit          m_started;
  bit          m_drop;
  logic [15:0] m_pc;
  logic [15:0] m_tgt;
  rec_t        m_buf[$];
  logic [15:0] m_instr;
  logic [15:0] m_pc1;
  bit          m_valid;

  function automatic void m_reset();
    m_started = 0;
    m_drop    = 0;
    m_pc      = 16'h0000;
    m_tgt     = 16'h0000;
    m_buf.delete();
    m_instr   = 16'h0000;
    m_pc1     = 16'h0000;
    m_valid   = 0;
  endfunction

  function automatic bit m_req();
    return m_started && (m_buf.size() == 0);
  endfunction

  function automatic void m_bubble();
    m_instr = 16'h0000;
    m_valid = 0;
  endfunction

  function automatic void m_clock(input bit st, input bit rd,
                                  input logic [15:0] rpc,
                                  input bit rdy,
                                  input logic [15:0] dat);
    bit   r;
    rec_t e;
    r = m_req();
    if (rd) begin
      m_buf.delete();
      m_bubble();
      if (r && !rdy) begin
        m_drop = 1;
        m_tgt  = rpc;
      end else begin
        m_drop = 0;
        m_pc   = rpc;
      end
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
      if (!st) m_bubble();
    end else if (m_drop) begin
      if (rdy) begin
        m_drop = 0;
        m_pc   = m_tgt;
      end
      if (!st) m_bubble();
    end else if (m_buf.size() != 0) begin
      if (!st) begin
        e       = m_buf.pop_front();
        m_instr = e.instr;
        m_pc1   = e.pc1;
        m_valid = 1;
      end
    end else if (rdy) begin
      e.instr = dat;
      e.pc1   = m_pc + 16'd1;
      if (st) m_buf.push_back(e);
      else begin
        m_instr = e.instr;
        m_pc1   = e.pc1;
        m_valid = 1;
      end
      m_pc = m_pc + 16'd1;
    end else if (!st) begin
      m_bubble();
    end
  endfunction

  task automatic check_model(input string tag);
    logic [15:0] ei;
    ei = m_instr;
    cmp({tag, ".req"}, 16'(imem_req), 16'(m_req()));
    cmp({tag, ".addr"}, imem_addr, m_pc);
    cmp({tag, ".instr"}, if_id_instr, m_instr);
    cmp({tag, ".pc1"}, if_id_pc1, m_pc1);
    cmp({tag, ".valid"}, 16'(if_id_valid), 16'(m_valid));
    cmp({tag, ".opcode"}, 16'(opcode), 16'(ei[15:12]));
  endtask

  task automatic step(input bit st, input bit rd,
                      input logic [15:0] rpc, input bit rdy,
                      input logic [15:0] dat, input string tag);
    bit g;
    g           = rdy && m_req();
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdy    = g;
    imem_data   = dat;
    @(posedge clk);
    m_clock(st, rd, rpc, g, dat);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    cmp({tag, ".req"}, 16'(imem_req), 16'h0);
    cmp({tag, ".addr"}, imem_addr, 16'h0000);
    cmp({tag, ".instr"}, if_id_instr, 16'h0000);
    cmp({tag, ".pc1"}, if_id_pc1, 16'h0000);
    cmp({tag, ".valid"}, 16'(if_id_valid), 16'h0);
    cmp({tag, ".opcode"}, 16'(opcode), 16'h0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit          st;
    bit          rd;
    logic [15:0] rpc;
    bit          rdy;
    logic [15:0] dat;
    bit          e_req;
    logic [15:0] e_addr;
    logic [15:0] e_instr;
    logic [15:0] e_pc1;
    bit          e_valid;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit st, bit rd, logic [15:0] rpc,
                              bit rdy, logic [15:0] dat, bit rq,
                              logic [15:0] ad, logic [15:0] ins,
                              logic [15:0] p1, bit v);
    vec_t x;
    x = '{st, rd, rpc, rdy, dat, rq, ad, ins, p1, v};
    tbl.push_back(x);
  endfunction

  initial begin
    logic [15:0] ti;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_rdy    = 1'b0;
    imem_data   = 16'h0000;
    m_reset();

    //  st rd rpc      rdy dat      req addr     instr    pc1      v
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 0);
    add(0, 0, 16'h0, 1, 16'h1234, 1, 16'h0001, 16'h1234, 16'h0001, 1);
    add(0, 0, 16'h0, 1, 16'h2345, 1, 16'h0002, 16'h2345, 16'h0002, 1);
    add(0, 0, 16'h0, 1, 16'h3456, 1, 16'h0003, 16'h3456, 16'h0003, 1);
    add(0, 0, 16'h0, 1, 16'h4567, 1, 16'h0004, 16'h4567, 16'h0004, 1);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0004, 16'h0000, 16'h0004, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0004, 16'h0000, 16'h0004, 0);
    add(0, 0, 16'h0, 1, 16'h5678, 1, 16'h0005, 16'h5678, 16'h0005, 1);
    add(1, 0, 16'h0, 1, 16'h6789, 0, 16'h0006, 16'h5678, 16'h0005, 1);
    add(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0006, 16'h5678, 16'h0005, 1);
    add(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0006, 16'h5678, 16'h0005, 1);
    add(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0006, 16'h5678, 16'h0005, 1);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0006, 16'h6789, 16'h0006, 1);
    add(0, 1, 16'h0040, 0, 16'h0, 1, 16'h0006, 16'h0000, 16'h0006, 0);
    add(0, 0, 16'h0, 0, 16'h0000, 1, 16'h0006, 16'h0000, 16'h0006, 0);
    add(0, 0, 16'h0, 1, 16'hABCD, 1, 16'h0040, 16'h0000, 16'h0006, 0);
    add(0, 0, 16'h0, 1, 16'h7001, 1, 16'h0041, 16'h7001, 16'h0041, 1);
    add(1, 1, 16'h0100, 1, 16'h8002, 1, 16'h0100, 16'h0000, 16'h0041, 0);
    add(1, 0, 16'h0, 1, 16'h9003, 0, 16'h0101, 16'h0000, 16'h0041, 0);
    add(1, 1, 16'h0200, 0, 16'h0, 1, 16'h0200, 16'h0000, 16'h0041, 0);
    add(0, 0, 16'h0, 1, 16'hC004, 1, 16'h0201, 16'hC004, 16'h0201, 1);
    add(0, 1, 16'hFFFF, 0, 16'h0, 1, 16'h0201, 16'h0000, 16'h0201, 0);
    add(0, 1, 16'hFFFF, 1, 16'h1111, 1, 16'hFFFF, 16'h0000, 16'h0201, 0);
    add(0, 0, 16'h0, 1, 16'hD005, 1, 16'h0000, 16'hD005, 16'h0000, 1);
    add(0, 1, 16'h0300, 0, 16'h0, 1, 16'h0000, 16'h0000, 16'h0000, 0);
    add(0, 1, 16'h0310, 0, 16'h0, 1, 16'h0000, 16'h0000, 16'h0000, 0);
    add(0, 0, 16'h0, 1, 16'hEEEE, 1, 16'h0310, 16'h0000, 16'h0000, 0);
    add(0, 0, 16'h0, 1, 16'hE006, 1, 16'h0311, 16'hE006, 16'h0311, 1);

    // reset state
    #12;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].rdy, tbl[i].dat,
           $sformatf("vec%0d", i));
      ti = tbl[i].e_instr;
      cmp($sformatf("tbl%0d.req", i), 16'(imem_req), 16'(tbl[i].e_req));
      cmp($sformatf("tbl%0d.addr", i), imem_addr, tbl[i].e_addr);
      cmp($sformatf("tbl%0d.instr", i), if_id_instr, tbl[i].e_instr);
      cmp($sformatf("tbl%0d.pc1", i), if_id_pc1, tbl[i].e_pc1);
      cmp($sformatf("tbl%0d.valid", i), 16'(if_id_valid),
          16'(tbl[i].e_valid));
      cmp($sformatf("tbl%0d.op", i), 16'(opcode), 16'(ti[15:12]));
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                       : 16'($urandom);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rp,
           $urandom_range(0, 1) == 1, 16'($urandom), "rnd");
    end

    // reset while a request is outstanding
    step(0, 1, 16'h0500, 0, 16'h0, "pre_rst");
    step(0, 0, 16'h0, 0, 16'h0, "pre_rst2");
    cmp("pre_rst.req_up", 16'(imem_req), 16'h1);
    stall     = 1'b0;
    redirect  = 1'b0;
    imem_rdy  = 1'b1;
    imem_data = 16'hF00D;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    check_reset_vals("held_rst");
    imem_rdy = 1'b0;
    rst_n    = 1'b1;
    m_reset();
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           16'($urandom), $urandom_range(0, 1) == 1, 16'($urandom),
           "post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_if_id_stage.md
# fetch_if_id_stage

Instruction-fetch stage and IF/ID pipeline register of the WISC-S15 16-bit core. Holds the word-addressed PC, runs a variable-latency request/ready handshake with instruction memory, absorbs decode stalls through a one-entry skid buffer, and squashes wrong-path fetches on redirect (branch, call, return). Its registered `opcode` output drives `Control_Logic` directly; the rest of the IF/ID payload feeds register-file read and the ID/EX register.

## Interface
- `RESET_PC`, 16'h0000, first fetch address after reset
- `NOP_INSTR`, 16'h0000, bubble encoding (ADD R0,R0,R0; R0 writes are discarded by the register file)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request; held high until accepted
- `imem_addr`  out  16  word address of the request; stable while `imem_req` is high
- `imem_rdy`  in  1  memory response; may assert in the same cycle as `imem_req`
- `imem_data`  in  16  instruction; valid only when `imem_rdy`=1
- `stall`  in  1  decode stage cannot accept a new instruction
- `redirect`  in  1  control-flow change resolved downstream
- `redirect_pc`  in  16  target address; sampled when `redirect`=1
- `if_id_instr`  out  16  registered instruction
- `if_id_pc1`  out  16  registered PC+1 of that instruction, for CALL link and branch offset
- `if_id_valid`  out  1  payload is a real instruction; 0 marks a bubble
- `opcode`  out  4  `if_id_instr[15:12]`, fed to `Control_Logic`

## Operation
- States: `S_RESET`, `S_FETCH`, `S_DROP`, `S_SKID`.
- `S_RESET`: entered asynchronously on reset. Leaves to `S_FETCH` on the first clock after `rst_n` rises. `imem_req`=0 in this state.
- `S_FETCH`: `imem_req`=1, `imem_addr`=PC.
  - On `imem_rdy` with no stall: IF/ID loads {`imem_data`, PC+1, valid=1} and PC increments by 1.
  - On `imem_rdy` with `stall`: IF/ID holds, the response goes into the skid buffer, PC increments, and the state goes to `S_SKID`.
- `S_SKID`: `imem_req`=0. When `stall` drops, the buffer moves into IF/ID, the buffer clears, and the state returns to `S_FETCH`.
- `S_DROP`: entered when `redirect` arrives while a request is outstanding but not yet accepted. `imem_req` stays high on the old address until `imem_rdy`. That response is discarded. The state then returns to `S_FETCH` with PC=`redirect_pc`, held in an internal target register.
- Redirect priority, in every state: redirect wins over `stall` and over `imem_rdy` data.
  - IF/ID becomes a bubble: `NOP_INSTR`, valid=0, `if_id_pc1` unchanged.
  - The skid buffer clears.
  - PC loads `redirect_pc`.
- A redirect in the same cycle as `imem_rdy` discards the data and goes straight to `S_FETCH` at the target.
- A second redirect while in `S_DROP` overwrites the target register.
- While stalled without a redirect, IF/ID is held bit-for-bit, valid included.
- If the pipeline is not stalled and no response arrives in a cycle, IF/ID loads a bubble (valid=0).
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 wraps to 16'h0000, with no flag.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `if_id_instr`=`NOP_INSTR`, `if_id_pc1`=`RESET_PC`, `if_id_valid`=0, `opcode`=4'h0
  - PC=`RESET_PC`, skid buffer empty
- Latency: `imem_rdy` at edge N puts the instruction on `if_id_*`/`opcode` after edge N. Peak throughput with a zero-wait memory is 1 instruction per cycle.
- The first request is raised in the cycle after reset deasserts.
- Redirect at edge N: `imem_addr`=`redirect_pc` after N, unless a request is still outstanding, in which case `S_DROP` applies.
- Skid release: one cycle after `stall` falls, `if_id_*` holds the buffered instruction. The next request issues in that same cycle.
- Reset mid-request: all state clears immediately and the pending response is ignored.

## Structure
- Shared package `wisc_pkg`:
  - 4-bit opcode constants ADD…ERR, shared with `Control_Logic`
  - `NOP_INSTR`
  - `fetch_state_t` enum
  - `if_id_t` struct {instr, pc1, valid}
- One sub-module, `fetch_skid_buf`: a one-entry `if_id_t` holding register with load, clear, and a valid flag.

## Test plan
- Zero-wait memory returning instructions at 0x0000..0x0003 → `opcode` sequence matches each instr[15:12] on consecutive cycles; `if_id_pc1`=1,2,3,4; `if_id_valid`=1 throughout.
- 3-cycle memory latency → `imem_addr` stable for 3 cycles; IF/ID valid=0 between instructions; PC advances by 1 per accepted fetch.
- `stall` raised for 4 cycles while a response arrives → IF/ID held; `imem_req`=0 in `S_SKID`; buffered instruction appears 1 cycle after `stall` falls; no instruction lost or duplicated.
- `redirect`=1, `redirect_pc`=16'h0040, with a request pending and `imem_rdy` 2 cycles later → that response is dropped; next `imem_addr`=0x0040; IF/ID is a bubble (instr 16'h0000, valid 0).
- `redirect` concurrent with `stall` and `imem_rdy` → bubble, buffer empty, PC=target.
- PC=16'hFFFF fetch → `if_id_pc1`=16'h0000; `rst_n` pulled low mid-request → all outputs at reset values asynchronously.
